// File: rtl/tick_sync_ctrl.sv
// Per-tick packet accounting: counts packets sent and received during a tick window and
// raises a one-cycle tick_ready once every sent packet has arrived or the drain timeout expires.
module tick_sync_ctrl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic [NUM_SRC-1:0] sent_valid,
  input  logic               recv_valid,
  input  logic               drain_done,
  input  logic [TMO_W-1:0]   tmo_limit,
  output logic               tick_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   sent_count,
  output logic [CNT_W-1:0]   recv_count,
  output logic               ovf_err,
  output logic               tmo_err
);

  localparam int unsigned PopW = $clog2(NUM_SRC + 1);
  localparam int unsigned SumW = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StCount, StWaitRx, StReady} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   sent_q, sent_d, recv_q, recv_d;
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic               ovf_q, ovf_d, tmo_q, tmo_d;
  logic               tick_ready_q, busy_q;
  logic [PopW-1:0]    pop;
  logic [SumW-1:0]    sent_sum, recv_sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pop = pop + PopW'(sent_valid[i]);
    end
  end

  // One extra bit on each sum exposes the carry used for saturation.
  assign sent_sum = {1'b0, sent_q} + SumW'(pop);
  assign recv_sum = {1'b0, recv_q} + SumW'(recv_valid);

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          sent_d  = '0;
          recv_d  = '0;
          timer_d = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = StCount;
        end
      end
      StCount, StWaitRx: begin
        if (sent_sum[CNT_W]) begin
          sent_d = '1;
          ovf_d  = 1'b1;
        end else begin
          sent_d = sent_sum[CNT_W-1:0];
        end
        if (recv_sum[CNT_W]) begin
          recv_d = '1;
          ovf_d  = 1'b1;
        end else begin
          recv_d = recv_sum[CNT_W-1:0];
        end
        if (recv_d > sent_d) begin
          ovf_d = 1'b1;
        end
        if (state_q == StCount) begin
          if (drain_done) begin
            state_d = StWaitRx;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          // Match uses next-state counts so same-cycle arrivals close the tick at once.
          if (recv_d == sent_d) begin
            state_d = StReady;
          end else if ((tmo_limit != '0) && (timer_d >= tmo_limit)) begin
            tmo_d   = 1'b1;
            state_d = StReady;
          end
        end
      end
      StReady: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sent_q       <= '0;
      recv_q       <= '0;
      timer_q      <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      tick_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sent_q       <= sent_d;
      recv_q       <= recv_d;
      timer_q      <= timer_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      tick_ready_q <= (state_d == StReady);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign tick_ready = tick_ready_q;
  assign busy       = busy_q;
  assign sent_count = sent_q;
  assign recv_count = recv_q;
  assign ovf_err    = ovf_q;
  assign tmo_err    = tmo_q;

endmodule

// File: tb/tb_tick_sync_ctrl.sv
// Scenario bench for tick_sync_ctrl: expected tick results are queued when a tick's traffic is
// driven and checked when tick_ready fires; a narrow-counter instance covers saturation.
module tb_tick_sync_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] sent_valid = '0;
  logic       recv_valid = 1'b0;
  logic       drain_done = 1'b0;
  logic [15:0] tmo_limit = '0;

  logic       tick_ready, busy, ovf_err, tmo_err;
  logic [7:0] sent_count, recv_count;
  logic       tick_ready4, busy4, ovf_err4, tmo_err4;
  logic [3:0] sent_count4, recv_count4;

  typedef struct packed {
    logic [7:0] sent;
    logic [7:0] recv;
    logic       ovf;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;

  tick_sync_ctrl #(.NUM_SRC(4), .CNT_W(8), .TMO_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .sent_valid(sent_valid),
    .recv_valid(recv_valid), .drain_done(drain_done), .tmo_limit(tmo_limit),
    .tick_ready(tick_ready), .busy(busy), .sent_count(sent_count), .recv_count(recv_count),
    .ovf_err(ovf_err), .tmo_err(tmo_err)
  );

  tick_sync_ctrl #(.NUM_SRC(4), .CNT_W(4), .TMO_W(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .sent_valid(sent_valid),
    .recv_valid(recv_valid), .drain_done(drain_done), .tmo_limit(tmo_limit),
    .tick_ready(tick_ready4), .busy(busy4), .sent_count(sent_count4), .recv_count(recv_count4),
    .ovf_err(ovf_err4), .tmo_err(tmo_err4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({tick_ready, busy, ovf_err, tmo_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {tick_ready, busy, ovf_err, tmo_err});
    end
    n_checks++;
    if (sent_count !== 8'd0 || recv_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", sent_count, recv_count);
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency busy got %b want 1", busy);
    end
    sent_valid = 4'b1011;
    step();
    tick = 1'b1;  // must be ignored while counting
    step();
    tick = 1'b0;
    sent_valid = '0;
    drain_done = 1'b1;
    sb.push_back('{sent: 8'd6, recv: 8'd6, ovf: 1'b0, tmo: 1'b0});
    step();
    drain_done = 1'b0;
    n_checks++;
    if (sent_count !== 8'd6) begin
      n_fail++;
      $display("FAIL basic_sent got %0d want 6", sent_count);
    end
    recv_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i < 6) begin
        n_checks++;
        if (tick_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early_ready at recv %0d got %b want 0", i, tick_ready);
        end
      end
    end
    recv_valid = 1'b0;
    n_checks++;
    if (tick_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready got %b want 1", tick_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL basic_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL basic_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    step();
    n_checks++;
    if (tick_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle got ready=%b busy=%b want 0 0", tick_ready, busy);
    end
  endtask

  task automatic test_no_traffic();
    tick = 1'b1;
    step();
    tick = 1'b0;
    drain_done = 1'b1;
    sb.push_back('{sent: 8'd0, recv: 8'd0, ovf: 1'b0, tmo: 1'b0});
    step();
    drain_done = 1'b0;
    n_checks++;
    if (tick_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_wait got ready=%b busy=%b want 0 1", tick_ready, busy);
    end
    step();
    n_checks++;
    if (tick_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_ready got %b want 1", tick_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL empty_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL empty_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    tmo_limit = 16'd10;
    tick = 1'b1;
    step();
    tick = 1'b0;
    sent_valid = 4'b0111;
    recv_valid = 1'b1;
    step();
    sent_valid = '0;
    recv_valid = 1'b0;
    drain_done = 1'b1;
    sb.push_back('{sent: 8'd3, recv: 8'd1, ovf: 1'b0, tmo: 1'b1});
    step();
    drain_done = 1'b0;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (tick_ready === 1'b1) break;
    end
    n_checks++;
    if (n != 10 || tick_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_cycles got %0d (ready=%b) want 10", n, tick_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL tmo_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL tmo_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    tick = 1'b1;  // lands in the READY cycle, must not restart
    step();
    tick = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || tmo_err !== 1'b1 || sent_count !== 8'd3 || recv_count !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_hold got busy=%b tmo=%b %0d/%0d want 0 1 3/1",
               busy, tmo_err, sent_count, recv_count);
    end
    tmo_limit = '0;
  endtask

  task automatic test_saturate();
    int n;
    tmo_limit = 16'd3;
    tick = 1'b1;
    step();
    tick = 1'b0;
    sent_valid = 4'b1111;
    repeat (4) step();
    sent_valid = 4'b0001;
    step();
    sent_valid = '0;
    n_checks++;
    if (sent_count4 !== 4'd15 || ovf_err4 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_narrow got %0d ovf=%b want 15 ovf=1", sent_count4, ovf_err4);
    end
    drain_done = 1'b1;
    sb.push_back('{sent: 8'd17, recv: 8'd0, ovf: 1'b0, tmo: 1'b1});
    step();
    drain_done = 1'b0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (tick_ready === 1'b1) break;
    end
    n_checks++;
    if (n != 3 || tick_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_tmo_cycles got %0d (ready4=%b) want 3", n, tick_ready4);
    end
    n_checks++;
    if (sent_count4 !== 4'd15 || ovf_err4 !== 1'b1 || tmo_err4 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_narrow_end got %0d ovf=%b tmo=%b want 15 1 1",
               sent_count4, ovf_err4, tmo_err4);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sat_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL sat_wide_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    step();
    tmo_limit = '0;
  endtask

  task automatic test_recv_excess();
    tick = 1'b1;
    step();
    tick = 1'b0;
    recv_valid = 1'b1;
    step();
    recv_valid = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL excess_flag got ovf=%b busy=%b want 1 1", ovf_err, busy);
    end
    sent_valid = 4'b0001;
    step();
    sent_valid = '0;
    drain_done = 1'b1;
    sb.push_back('{sent: 8'd1, recv: 8'd1, ovf: 1'b1, tmo: 1'b0});
    step();
    drain_done = 1'b0;
    step();
    n_checks++;
    if (tick_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL excess_ready got %b want 1", tick_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL excess_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL excess_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    step();
  endtask

  task automatic test_same_cycle();
    tick = 1'b1;
    step();
    tick = 1'b0;
    sent_valid = 4'b0001;
    recv_valid = 1'b1;
    drain_done = 1'b1;
    step();
    drain_done = 1'b0;
    sb.push_back('{sent: 8'd2, recv: 8'd2, ovf: 1'b0, tmo: 1'b0});
    step();
    sent_valid = '0;
    recv_valid = 1'b0;
    n_checks++;
    if (tick_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_ready got %b want 1", tick_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL same_cycle_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL same_cycle_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    tick = 1'b1;
    step();
    tick = 1'b0;
    recv_valid = 1'b1;
    step();
    recv_valid = 1'b0;
    sent_valid = 4'b0011;
    drain_done = 1'b1;
    step();
    sent_valid = '0;
    drain_done = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1 || ovf_err !== 1'b1 || sent_count !== 8'd2) begin
      n_fail++;
      $display("FAIL mid_pre got busy=%b ovf=%b sent=%0d want 1 1 2", busy, ovf_err, sent_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tick_ready, busy, ovf_err, tmo_err} !== 4'b0000 || sent_count !== 8'd0 ||
        recv_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_async got flags=%b %0d/%0d want 0000 0/0",
               {tick_ready, busy, ovf_err, tmo_err}, sent_count, recv_count);
    end
    #2;
    reset_n = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_restart busy got %b want 1", busy);
    end
    drain_done = 1'b1;
    sb.push_back('{sent: 8'd0, recv: 8'd0, ovf: 1'b0, tmo: 1'b0});
    step();
    drain_done = 1'b0;
    step();
    n_checks++;
    if (tick_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ready got %b want 1", tick_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL mid_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      if (sent_count !== e.sent || recv_count !== e.recv || ovf_err !== e.ovf ||
          tmo_err !== e.tmo) begin
        n_fail++;
        $display("FAIL mid_result got %0d/%0d ovf=%b tmo=%b want %0d/%0d ovf=%b tmo=%b",
                 sent_count, recv_count, ovf_err, tmo_err, e.sent, e.recv, e.ovf, e.tmo);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_traffic();
    test_timeout();
    test_saturate();
    test_recv_excess();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
